// File: rtl/rvv_axi_reg_slice.sv
// rvv_axi_reg_slice: five-channel AXI4 register slice with a per-channel bypass, skid or half-rate stage
//
// Ports:
//   clk_i, rst_i                      clock and synchronous active-high reset
//   s_{aw,w,ar}_{valid,ready,payload} request channels on the core side (inputs of the slice)
//   m_{aw,w,ar}_{valid,ready,payload} request channels on the fabric side (outputs of the slice)
//   m_{b,r}_{valid,ready,payload}     response channels on the fabric side (inputs of the slice)
//   s_{b,r}_{valid,ready,payload}     response channels on the core side (outputs of the slice)

module rvv_axi_slice #(
    parameter int W    = 8,
    parameter int MODE = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_payload,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_payload
);
    if (MODE == 0) begin : g_bypass
        assign out_valid   = in_valid;
        assign in_ready    = out_ready;
        assign out_payload = in_payload;
    end else if (MODE <= 2) begin : g_reg
        typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
        state_t       state;
        logic         rdy;
        logic         push, pop;
        logic [W-1:0] main_q, skid_q;
        assign push        = in_valid & rdy;
        assign pop         = (state != EMPTY) & out_ready;
        assign in_ready    = rdy;
        assign out_valid   = state != EMPTY;
        assign out_payload = main_q;
        // Half-rate mode reuses ONE as its FULL state; its ready drops whenever
        // an entry is held, so it never reaches TWO.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state  <= EMPTY;
                rdy    <= 1'b0;
                main_q <= '0;
                skid_q <= '0;
            end else begin
                case (state)
                    EMPTY: begin
                        rdy <= push ? (MODE == 1) : 1'b1;
                        if (push) begin
                            state  <= ONE;
                            main_q <= in_payload;
                        end
                    end
                    ONE: begin
                        if (push && !pop) begin
                            state  <= TWO;
                            skid_q <= in_payload;
                            rdy    <= 1'b0;
                        end else if (push && pop) begin
                            main_q <= in_payload;
                        end else if (pop) begin
                            state <= EMPTY;
                            rdy   <= 1'b1;
                        end
                    end
                    TWO: begin
                        if (pop) begin
                            state  <= ONE;
                            main_q <= skid_q;
                            rdy    <= 1'b1;
                        end
                    end
                    default: begin
                        state <= EMPTY;
                        rdy   <= 1'b0;
                    end
                endcase
            end
        end
    end else begin : g_bad_mode
        $error("rvv_axi_slice: MODE must be 0, 1 or 2");
    end
endmodule

module rvv_axi_reg_slice #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 128,
    parameter int ID_W    = 6,
    parameter int AW_MODE = 1,
    parameter int W_MODE  = 1,
    parameter int B_MODE  = 1,
    parameter int AR_MODE = 1,
    parameter int R_MODE  = 1,
    localparam int AX_PW  = ADDR_W + 3 + ID_W + 8 + 3 + 2 + 1 + 4 + 4 + 4,
    localparam int W_PW   = DATA_W + DATA_W / 8 + 1,
    localparam int B_PW   = ID_W + 2,
    localparam int R_PW   = DATA_W + ID_W + 2 + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             s_aw_valid,
    output logic             s_aw_ready,
    input  logic [AX_PW-1:0] s_aw_payload,
    output logic             m_aw_valid,
    input  logic             m_aw_ready,
    output logic [AX_PW-1:0] m_aw_payload,
    input  logic             s_w_valid,
    output logic             s_w_ready,
    input  logic [W_PW-1:0]  s_w_payload,
    output logic             m_w_valid,
    input  logic             m_w_ready,
    output logic [W_PW-1:0]  m_w_payload,
    input  logic             m_b_valid,
    output logic             m_b_ready,
    input  logic [B_PW-1:0]  m_b_payload,
    output logic             s_b_valid,
    input  logic             s_b_ready,
    output logic [B_PW-1:0]  s_b_payload,
    input  logic             s_ar_valid,
    output logic             s_ar_ready,
    input  logic [AX_PW-1:0] s_ar_payload,
    output logic             m_ar_valid,
    input  logic             m_ar_ready,
    output logic [AX_PW-1:0] m_ar_payload,
    input  logic             m_r_valid,
    output logic             m_r_ready,
    input  logic [R_PW-1:0]  m_r_payload,
    output logic             s_r_valid,
    input  logic             s_r_ready,
    output logic [R_PW-1:0]  s_r_payload
);
    if (DATA_W % 8 != 0 || ID_W < 1) begin : g_bad_param
        $error("rvv_axi_reg_slice: DATA_W must be a multiple of 8 and ID_W at least 1");
    end

    rvv_axi_slice #(.W(AX_PW), .MODE(AW_MODE)) u_aw (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid(s_aw_valid), .in_ready(s_aw_ready), .in_payload(s_aw_payload),
        .out_valid(m_aw_valid), .out_ready(m_aw_ready), .out_payload(m_aw_payload)
    );

    rvv_axi_slice #(.W(W_PW), .MODE(W_MODE)) u_w (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid(s_w_valid), .in_ready(s_w_ready), .in_payload(s_w_payload),
        .out_valid(m_w_valid), .out_ready(m_w_ready), .out_payload(m_w_payload)
    );

    // Responses flow fabric -> core, so the fabric side is the slice input.
    rvv_axi_slice #(.W(B_PW), .MODE(B_MODE)) u_b (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid(m_b_valid), .in_ready(m_b_ready), .in_payload(m_b_payload),
        .out_valid(s_b_valid), .out_ready(s_b_ready), .out_payload(s_b_payload)
    );

    rvv_axi_slice #(.W(AX_PW), .MODE(AR_MODE)) u_ar (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid(s_ar_valid), .in_ready(s_ar_ready), .in_payload(s_ar_payload),
        .out_valid(m_ar_valid), .out_ready(m_ar_ready), .out_payload(m_ar_payload)
    );

    rvv_axi_slice #(.W(R_PW), .MODE(R_MODE)) u_r (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid(m_r_valid), .in_ready(m_r_ready), .in_payload(m_r_payload),
        .out_valid(s_r_valid), .out_ready(s_r_ready), .out_payload(s_r_payload)
    );
endmodule
